ps2_key_state_decoder: RTL and testbench

Synchronous scan-code decoder between `PS2_Controller` and the game logic. It consumes the controller's one-cycle received-byte strobe and byte. It tracks make codes, break codes (`F0`) and extended codes (`E0`), and maintains a held-key vector for the 29 playable keys. For each state change it emits a single-cycle press/release event. Everything runs on `CLOCK_50`, and the downstream `MasterFSM` and `mainStateHandler` sample its outputs.

---
 rtl/ps2_key_state_decoder.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_state_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_state_decoder.sv
// PS/2 scan-code decoder: follows make, break (F0) and extended (E0) sequences.
// It keeps a held-key vector for the 29 playable keys and emits a one-cycle
// press/release event whenever a bit of that vector changes.
module ps2_key_state_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int CNT_W          = 22
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [7:0]  recievedData,
    input  logic        recievedNewData,
    output logic [28:0] keyState,
    output logic        keyEvent,
    output logic [4:0]  eventKeyIndex,
    output logic        eventIsPress,
    output logic        releasePending
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       BREAK_CODE = 8'hF0;
    localparam logic [7:0]       EXT_CODE   = 8'hE0;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [28:0]       key_q, key_d;
    logic              evt_q, evt_d;
    logic [4:0]        idx_q, idx_d;
    logic              press_q, press_d;

    logic              map_hit;
    logic [4:0]        map_idx;
    logic              map_held;

    // Translate the incoming make code to a playable-key index.
    always_comb begin
        map_hit = 1'b1;
        map_idx = 5'd0;
        case (recievedData)
            8'h0E: map_idx = 5'd0;
            8'h16: map_idx = 5'd1;
            8'h1E: map_idx = 5'd2;
            8'h26: map_idx = 5'd3;
            8'h25: map_idx = 5'd4;
            8'h2E: map_idx = 5'd5;
            8'h36: map_idx = 5'd6;
            8'h3D: map_idx = 5'd7;
            8'h3E: map_idx = 5'd8;
            8'h46: map_idx = 5'd9;
            8'h45: map_idx = 5'd10;
            8'h4E: map_idx = 5'd11;
            8'h55: map_idx = 5'd12;
            8'h66: map_idx = 5'd13;
            8'h0D: map_idx = 5'd14;
            8'h15: map_idx = 5'd15;
            8'h1D: map_idx = 5'd16;
            8'h24: map_idx = 5'd17;
            8'h2D: map_idx = 5'd18;
            8'h2C: map_idx = 5'd19;
            8'h35: map_idx = 5'd20;
            8'h3C: map_idx = 5'd21;
            8'h43: map_idx = 5'd22;
            8'h44: map_idx = 5'd23;
            8'h4D: map_idx = 5'd24;
            8'h54: map_idx = 5'd25;
            8'h5B: map_idx = 5'd26;
            8'h5D: map_idx = 5'd27;
            8'h29: map_idx = 5'd28;
            default: map_hit = 1'b0;
        endcase
    end

    assign map_held = key_q[map_idx];

    // Next-state, key vector, event and timeout-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        evt_d   = 1'b0;
        idx_d   = idx_q;
        press_d = press_q;
        if (recievedNewData) begin
            // A byte always takes priority over an expiry on the same cycle.
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (recievedData == BREAK_CODE) begin
                        state_d = S_BRK;
                    end else if (recievedData == EXT_CODE) begin
                        state_d = S_EXT;
                    end else if (map_hit && !map_held) begin
                        key_d[map_idx] = 1'b1;
                        evt_d          = 1'b1;
                        idx_d          = map_idx;
                        press_d        = 1'b1;
                    end
                end
                S_BRK: begin
                    if (map_hit) begin
                        state_d = S_IDLE;
                        if (map_held) begin
                            key_d[map_idx] = 1'b0;
                            evt_d          = 1'b1;
                            idx_d          = map_idx;
                            press_d        = 1'b0;
                        end
                    end else if (recievedData == BREAK_CODE) begin
                        state_d = S_BRK;
                    end else if (recievedData == EXT_CODE) begin
                        state_d = S_EXT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EXT: begin
                    // Extended keys are not playable; only the break prefix matters.
                    state_d = (recievedData == BREAK_CODE) ? S_EXT_BRK : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            // A prefix left dangling too long is discarded silently.
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            evt_q   <= 1'b0;
            idx_q   <= 5'd0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            evt_q   <= evt_d;
            idx_q   <= idx_d;
            press_q <= press_d;
        end
    end

    assign keyState       = key_q;
    assign keyEvent       = evt_q;
    assign eventKeyIndex  = idx_q;
    assign eventIsPress   = press_q;
    assign releasePending = (state_q == S_BRK) || (state_q == S_EXT_BRK);

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
// Scoreboard bench for ps2_key_state_decoder: a flag-based reference model
// predicts key state, release-pending and events; a monitor checks them.
module tb_ps2_key_state_decoder;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        stb = 1'b0;
    logic [28:0] key_state;
    logic        key_event;
    logic [4:0]  ev_idx;
    logic        ev_press;
    logic        rel_pend;

    ps2_key_state_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .CLOCK_50        (clk),
        .resetn          (rst),
        .recievedData    (data),
        .recievedNewData (stb),
        .keyState        (key_state),
        .keyEvent        (key_event),
        .eventKeyIndex   (ev_idx),
        .eventIsPress    (ev_press),
        .releasePending  (rel_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit press;
    } ev_t;

    ev_t         evq[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  codes [29];

    // Reference model state: pending prefix flags and strobe-free edge count.
    bit          m_brk, m_ext;
    int          m_gap;
    logic [28:0] m_keys;
    bit          m_event;

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 29; i++)
            if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_brk = 0; m_ext = 0; m_gap = 0; m_keys = '0; m_event = 0;
    endfunction

    // Predict the effect of the next clock edge given this cycle's inputs.
    function automatic void model_step(input bit s, input logic [7:0] b);
        int k;
        ev_t e;
        m_event = 0;
        if (!s) begin
            m_gap++;
            if (m_gap >= T) begin m_brk = 0; m_ext = 0; end
            return;
        end
        m_gap = 0;
        k = lookup(b);
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1; else m_ext = 0;
        end else if (m_brk) begin
            if (k >= 0) begin
                m_brk = 0;
                if (m_keys[k]) begin
                    m_keys[k] = 1'b0; m_event = 1;
                    e.idx = k; e.press = 0; evq.push_back(e);
                end
            end else if (b == 8'hE0) begin
                m_brk = 0; m_ext = 1;
            end else if (b != 8'hF0) begin
                m_brk = 0;
            end
        end else begin
            if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_ext = 1;
            else if (k >= 0 && !m_keys[k]) begin
                m_keys[k] = 1'b1; m_event = 1;
                e.idx = k; e.press = 1; evq.push_back(e);
            end
        end
    endfunction

    task automatic cyc(input bit s, input logic [7:0] b);
        @(negedge clk);
        stb  = s;
        data = b;
        model_step(s, b);
    endtask

    task automatic send(input logic [7:0] b);
        $display("byte %02h", b);
        cyc(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        stb = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_keyState", 32'(key_state), 32'd0);
        check("rst_keyEvent", 32'(key_event), 32'd0);
        check("rst_index", 32'(ev_idx), 32'd0);
        check("rst_isPress", 32'(ev_press), 32'd0);
        check("rst_releasePending", 32'(rel_pend), 32'd0);
        model_clear();
        evq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare per-cycle state and pop the scoreboard on every event.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("keyState", 32'(key_state), 32'(m_keys));
            check("keyEvent", 32'(key_event), 32'(m_event));
            check("releasePending", 32'(rel_pend), 32'(m_brk));
            if (key_event) begin
                if (evq.size() == 0) begin
                    check("unexpected_event", 32'(ev_idx), 32'hFFFF);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    $display("event idx=%0d press=%0b", ev_idx, ev_press);
                    check("eventKeyIndex", 32'(ev_idx), 32'(e.idx));
                    check("eventIsPress", 32'(ev_press), 32'(e.press));
                end
            end
        end
    end

    initial begin
        logic [7:0] tbl [29] = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15,
                                 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44,
                                 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};
        for (int i = 0; i < 29; i++) codes[i] = tbl[i];
        model_clear();

        do_reset();
        // Single press.
        send(8'h15); idle(2);
        // Typematic repeat then release.
        send(8'h15); send(8'h15); send(8'h15); send(8'hF0); send(8'h15); idle(2);
        // Two keys, release space.
        send(8'h29); send(8'h0E); send(8'hF0); send(8'h29); idle(2);
        send(8'hF0); send(8'h0E); idle(1);
        // Extended sequences never touch the key vector.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h29); idle(2);
        // Break prefix expires, then a byte just before expiry wins.
        send(8'hF0); idle(T); send(8'h16); idle(2);
        send(8'hF0); send(8'h16); idle(2);
        send(8'hF0); idle(T - 1); send(8'h16); idle(2);
        // Extended prefix expiry.
        send(8'hE0); idle(T); send(8'h1D); idle(2);
        // Reset in the middle of a break sequence.
        send(8'h1E); send(8'hF0);
        do_reset();
        send(8'h1E); idle(2);

        // Randomized traffic with occasional long gaps.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 8)        send(codes[$urandom_range(0, 28)]);
            else if (r < 11)  send(8'hF0);
            else if (r < 13)  send(8'hE0);
            else if (r < 14)  send(8'($urandom_range(0, 255)));
            else if (r < 15)  idle($urandom_range(T - 2, T + 2));
            else              idle(1);
        end
        idle(T + 2);

        check("events_drained", 32'(evq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
